// File: rtl/seq_alu_nbit_if.sv
// Operand/result streaming bus for seq_alu_nbit: valid/ready operand input and result output.
interface seq_alu_nbit_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] inbus;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] outbus;
  logic         out_last;

  modport master (
    output in_valid, inbus, out_ready,
    input  in_ready, out_valid, outbus, out_last
  );

  modport slave (
    input  in_valid, inbus, out_ready,
    output in_ready, out_valid, outbus, out_last
  );
endinterface

// File: rtl/seq_alu_nbit.sv
// Sequential W-bit ALU: add, sub, Booth radix-2 signed multiply, non-restoring unsigned divide.
// Division is built only when SEQ_ALU_DIV_EN is defined; otherwise op=11 just flags err.
module seq_alu_nbit #(
  parameter int unsigned W = 8
) (
  input  logic       CLK,
  input  logic       Clr,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       err,
  output logic       carry,
  seq_alu_nbit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_Q, LOAD_M, CHECK, EXEC, CORR, OUT_A, OUT_Q
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [W-1:0]     a;
  logic [W-1:0]     q;
  logic [W-1:0]     m;
  logic             q_1;
  logic [CNT_W-1:0] cnt;

  logic             is_sub;
  logic             is_addsub;
  logic [W:0]       addsub_res;
  logic [W:0]       mul_sum;

  // Booth add/sub done one bit wider so M = most negative value cannot overflow
  always_comb begin
    is_sub     = (op_q == OP_SUB);
    is_addsub  = (op_q == OP_ADD) || is_sub;
    addsub_res = {1'b0, a} + {1'b0, m ^ {W{is_sub}}} + (W+1)'(is_sub);
    unique case ({q[0], q_1})
      2'b01:   mul_sum = {a[W-1], a} + {m[W-1], m};
      2'b10:   mul_sum = {a[W-1], a} - {m[W-1], m};
      default: mul_sum = {a[W-1], a};
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic       r_msb;
  logic [W:0] div_shift;
  logic [W:0] div_r_next;

  // Partial remainder R = {r_msb, a}; shift in next dividend bit then add or subtract divisor
  always_comb begin
    div_shift  = {a, q[W-1]};
    div_r_next = r_msb ? (div_shift + {1'b0, m}) : (div_shift - {1'b0, m});
  end
`endif

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
      carry <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_msb <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            err   <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            q_1   <= 1'b0;
            unique case (op)
              OP_MUL: begin
                a     <= '0;
                state <= LOAD_Q;
              end
`ifdef SEQ_ALU_DIV_EN
              OP_DIV:  state <= LOAD_A;
`else
              OP_DIV:  err <= 1'b1;
`endif
              default: state <= LOAD_A;
            endcase
          end
        end
        LOAD_A: if (bus.in_valid) begin
          a     <= bus.inbus;
          state <= (op_q == OP_DIV) ? LOAD_Q : LOAD_M;
        end
        LOAD_Q: if (bus.in_valid) begin
          q     <= bus.inbus;
          state <= LOAD_M;
        end
        LOAD_M: if (bus.in_valid) begin
          m     <= bus.inbus;
`ifdef SEQ_ALU_DIV_EN
          state <= (op_q == OP_DIV) ? CHECK : EXEC;
`else
          state <= EXEC;
`endif
        end
`ifdef SEQ_ALU_DIV_EN
        // Quotient would not fit in W bits (also catches divide by zero)
        CHECK: begin
          r_msb <= 1'b0;
          if (a >= m) begin
            err   <= 1'b1;
            state <= OUT_A;
          end else begin
            state <= EXEC;
          end
        end
        CORR: begin
          if (r_msb) a <= a + m;
          r_msb <= 1'b0;
          state <= OUT_A;
        end
`endif
        EXEC: begin
          if (is_addsub) begin
            {carry, a} <= addsub_res;
            state      <= OUT_A;
          end else if (op_q == OP_MUL) begin
            a     <= mul_sum[W:1];
            q     <= {mul_sum[0], q[W-1:1]};
            q_1   <= q[0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(W - 1)) state <= OUT_A;
          end else begin
`ifdef SEQ_ALU_DIV_EN
            {r_msb, a} <= div_r_next;
            q          <= {q[W-2:0], ~div_r_next[W]};
            cnt        <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(W - 1)) state <= CORR;
`else
            state <= IDLE;
`endif
          end
        end
        OUT_A: if (bus.out_ready) state <= is_addsub ? IDLE : OUT_Q;
        OUT_Q: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and bus outputs are pure decodes of registered state
  assign busy          = (state != IDLE);
  assign bus.in_ready  = (state == LOAD_A) || (state == LOAD_Q) || (state == LOAD_M);
  assign bus.out_valid = (state == OUT_A) || (state == OUT_Q);
  assign bus.out_last  = ((state == OUT_A) && is_addsub) || (state == OUT_Q);
  assign bus.outbus    = (state == OUT_A) ? a : ((state == OUT_Q) ? q : '0);

endmodule

// File: tb/tb_seq_alu_nbit.sv
// Directed self-checking bench for seq_alu_nbit at W=8; division vectors run when SEQ_ALU_DIV_EN is defined.
module tb_seq_alu_nbit;
  logic       CLK = 1'b0;
  logic       Clr;
  logic       start;
  logic [1:0] op;
  logic       busy, err, carry;
  int         checks = 0;
  int         failures = 0;

  seq_alu_nbit_if #(.W(8)) bif ();

  seq_alu_nbit #(.W(8)) dut (
    .CLK(CLK), .Clr(Clr), .start(start), .op(op),
    .busy(busy), .err(err), .carry(carry), .bus(bif)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: all are entered and left on a falling edge
  task automatic do_start(input logic [1:0] o);
    start = 1'b1; op = o;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n = 0;
    bif.in_valid = 1'b1; bif.inbus = w;
    while (!bif.in_ready && n < 50) begin @(negedge CLK); n++; end
    if (!bif.in_ready) begin
      checks++; failures++;
      $display("FAIL send_word timeout word=%h", w);
    end
    @(negedge CLK);
    bif.in_valid = 1'b0; bif.inbus = '0;
  endtask

  task automatic recv_word(output logic [7:0] w, output logic last);
    int n = 0;
    bif.out_ready = 1'b1;
    while (!bif.out_valid && n < 50) begin @(negedge CLK); n++; end
    if (!bif.out_valid) begin
      checks++; failures++;
      $display("FAIL recv_word timeout");
    end
    w = bif.outbus; last = bif.out_last;
    @(negedge CLK);
    bif.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    Clr = 1'b1;
    #1;
    checks++;
    if ({busy, err, carry, bif.in_ready, bif.out_valid, bif.out_last} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {busy, err, carry, bif.in_ready, bif.out_valid, bif.out_last});
    end
    checks++;
    if (bif.outbus !== 8'h00) begin
      failures++; $display("FAIL reset_outbus got=%h exp=00", bif.outbus);
    end
    @(negedge CLK);
    Clr = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_add;
    logic [7:0] w; logic l;
    do_start(2'b00); send_word(8'h7F); send_word(8'h01); recv_word(w, l);
    checks++;
    if ({w, l, carry, err} !== {8'h80, 3'b100}) begin
      failures++; $display("FAIL add_7f_01 got=%h last=%b c=%b e=%b exp=80 1 0 0", w, l, carry, err);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL add_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_sub;
    logic [7:0] w; logic l;
    do_start(2'b01); send_word(8'h05); send_word(8'h07); recv_word(w, l);
    checks++;
    if ({w, l, carry} !== {8'hFE, 2'b10}) begin
      failures++; $display("FAIL sub_05_07 got=%h last=%b c=%b exp=fe 1 0", w, l, carry);
    end
    do_start(2'b01); send_word(8'h07); send_word(8'h05); recv_word(w, l);
    checks++;
    if ({w, l, carry} !== {8'h02, 2'b11}) begin
      failures++; $display("FAIL sub_07_05 got=%h last=%b c=%b exp=02 1 1", w, l, carry);
    end
  endtask

  task automatic test_mul;
    logic [7:0] hi, lo; logic lh, ll; int n = 0;
    do_start(2'b10); send_word(8'hFD); send_word(8'h07);
    while (busy && !bif.in_ready && !bif.out_valid && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if (n != 8) begin failures++; $display("FAIL mul_exec_cycles got=%0d exp=8", n); end
    recv_word(hi, lh); recv_word(lo, ll);
    checks++;
    if ({hi, lo, lh, ll, carry, err} !== {16'hFFEB, 4'b0100}) begin
      failures++;
      $display("FAIL mul_m3_7 got=%h%h last=%b%b c=%b e=%b exp=ffeb 01 0 0", hi, lo, lh, ll, carry, err);
    end
    // Operand words presented during EXEC must be ignored
    do_start(2'b10); send_word(8'h80); send_word(8'h80);
    bif.in_valid = 1'b1; bif.inbus = 8'hAA;
    recv_word(hi, lh); recv_word(lo, ll);
    bif.in_valid = 1'b0;
    checks++;
    if ({hi, lo, lh, ll} !== {16'h4000, 2'b01}) begin
      failures++; $display("FAIL mul_80_80 got=%h%h last=%b%b exp=4000 01", hi, lo, lh, ll);
    end
  endtask

  task automatic test_stall;
    logic [7:0] w; logic l;
    do_start(2'b00); send_word(8'h11); send_word(8'h22);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bif.out_valid, bif.outbus} !== {1'b1, 8'h33}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b bus=%h exp=1 33", i, bif.out_valid, bif.outbus);
      end
      @(negedge CLK);
    end
    recv_word(w, l);
    checks++;
    if ({w, l} !== {8'h33, 1'b1}) begin
      failures++; $display("FAIL stall_word got=%h last=%b exp=33 1", w, l);
    end
  endtask

  task automatic test_clr_abort;
    logic [7:0] w; logic l;
    do_start(2'b10); send_word(8'h12); send_word(8'h34);
    @(negedge CLK); @(negedge CLK);
    #2 Clr = 1'b1;
    #1;
    checks++;
    if ({busy, err, carry, bif.in_ready, bif.out_valid, bif.out_last, bif.outbus} !== 14'b0) begin
      failures++;
      $display("FAIL clr_abort busy=%b valid=%b bus=%h exp=0 0 00", busy, bif.out_valid, bif.outbus);
    end
    @(negedge CLK);
    Clr = 1'b0;
    @(negedge CLK);
    do_start(2'b00); send_word(8'h10); send_word(8'h20); recv_word(w, l);
    checks++;
    if ({w, l, carry} !== {8'h30, 2'b10}) begin
      failures++; $display("FAIL clr_restart got=%h last=%b c=%b exp=30 1 0", w, l, carry);
    end
  endtask

`ifdef SEQ_ALU_DIV_EN
  task automatic test_div;
    logic [7:0] r, qt; logic lr, lq;
    do_start(2'b11); send_word(8'h00); send_word(8'h64); send_word(8'h07);
    recv_word(r, lr); recv_word(qt, lq);
    checks++;
    if ({r, qt, lr, lq, err} !== {16'h020E, 3'b010}) begin
      failures++; $display("FAIL div_100_7 got=%h %h last=%b%b e=%b exp=02 0e 01 0", r, qt, lr, lq, err);
    end
    do_start(2'b11); send_word(8'h00); send_word(8'h64); send_word(8'h00);
    recv_word(r, lr); recv_word(qt, lq);
    checks++;
    if ({r, qt, lq, err} !== {16'h0064, 2'b11}) begin
      failures++; $display("FAIL div_by_zero got=%h %h last=%b e=%b exp=00 64 1 1", r, qt, lq, err);
    end
  endtask
`else
  task automatic test_div_disabled;
    logic [7:0] w; logic l;
    do_start(2'b11);
    checks++;
    if ({err, busy, bif.in_ready} !== 3'b100) begin
      failures++; $display("FAIL div_off_err e=%b busy=%b rdy=%b exp=1 0 0", err, busy, bif.in_ready);
    end
    @(negedge CLK);
    checks++;
    if ({busy, bif.in_ready} !== 2'b00) begin
      failures++; $display("FAIL div_off_idle busy=%b rdy=%b exp=0 0", busy, bif.in_ready);
    end
  endtask
`endif

  task automatic test_err_clear;
    logic [7:0] w; logic l;
    do_start(2'b00); send_word(8'h01); send_word(8'h01); recv_word(w, l);
    checks++;
    if ({err, w} !== {1'b0, 8'h02}) begin
      failures++; $display("FAIL err_clear e=%b word=%h exp=0 02", err, w);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w; logic l; int n = 0;
    do_start(2'b00); send_word(8'h01); send_word(8'h02);
    bif.out_ready = 1'b1;
    while (!bif.out_valid && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if ({bif.outbus, bif.out_last} !== {8'h03, 1'b1}) begin
      failures++; $display("FAIL b2b_word got=%h last=%b exp=03 1", bif.outbus, bif.out_last);
    end
    start = 1'b1; op = 2'b00;
    @(negedge CLK);
    bif.out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_ignored busy=%b exp=0", busy); end
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if ({busy, bif.in_ready} !== 2'b11) begin
      failures++; $display("FAIL b2b_start_next busy=%b rdy=%b exp=1 1", busy, bif.in_ready);
    end
    send_word(8'h03); send_word(8'h04); recv_word(w, l);
    checks++;
    if ({w, l} !== {8'h07, 1'b1}) begin
      failures++; $display("FAIL b2b_second got=%h last=%b exp=07 1", w, l);
    end
  endtask

  initial begin
    start = 1'b0; op = 2'b00;
    bif.in_valid = 1'b0; bif.inbus = '0; bif.out_ready = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_stall;
    test_clr_abort;
`ifdef SEQ_ALU_DIV_EN
    test_div;
`else
    test_div_disabled;
`endif
    test_err_clear;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
